// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared field layout, types and bullet distance helper for sprite_compositor
package sprite_pkg;

  localparam int COORD_W        = 10;

  // Attribute word layout
  localparam int ATTR_EN_BIT    = 0;
  localparam int ATTR_X_LSB     = 1;
  localparam int ATTR_Y_LSB     = 11;
  localparam int ATTR_FRAME_LSB = 21;
  localparam int ATTR_FRAME_W   = 3;
  localparam int ATTR_HFLIP_BIT = 24;

  // Bullet word layout
  localparam int BUL_WORD_W     = 32;
  localparam int BUL_VALID_BIT  = 0;
  localparam int BUL_X_LSB      = 9;
  localparam int BUL_Y_LSB      = 19;

  typedef logic [23:0] rgb24_t;

  typedef struct packed {
    logic                      hflip;
    logic [ATTR_FRAME_W-1:0]   frame;
    logic [COORD_W-1:0]        y;
    logic [COORD_W-1:0]        x;
    logic                      en;
  } attr_t;

  // Squared-distance test using 12-bit signed deltas, widened before squaring
  function automatic logic bullet_in_radius(
    input logic [COORD_W-1:0] px,
    input logic [COORD_W-1:0] py,
    input logic [COORD_W-1:0] cx,
    input logic [COORD_W-1:0] cy,
    input logic signed [23:0] r_sq
  );
    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic signed [23:0] dxe;
    logic signed [23:0] dye;
    logic signed [23:0] d2;
    dx  = $signed({2'b00, px}) - $signed({2'b00, cx});
    dy  = $signed({2'b00, py}) - $signed({2'b00, cy});
    dxe = {{12{dx[11]}}, dx};
    dye = {{12{dy[11]}}, dy};
    d2  = dxe * dxe + dye * dye;
    return d2 <= r_sq;
  endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// rtl/sprite_hit_unit.sv - per-sprite bounding-box test and local texel coordinates
module sprite_hit_unit
  import sprite_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  localparam int LX_W = $clog2(SPR_W),
  localparam int LY_W = $clog2(SPR_H)
) (
  input  attr_t                attr,
  input  logic [COORD_W-1:0]   draw_x,
  input  logic [COORD_W-1:0]   draw_y,
  output logic                 hit,
  output logic [LX_W-1:0]      lx,
  output logic [LY_W-1:0]      ly
);

  // 11-bit compares keep boxes that extend past 1023 from wrapping to column 0
  logic [10:0] px, py, x0, y0, dx, dy;
  logic        unused_bits;

  assign px = {1'b0, draw_x};
  assign py = {1'b0, draw_y};
  assign x0 = {1'b0, attr.x};
  assign y0 = {1'b0, attr.y};
  assign dx = px - x0;
  assign dy = py - y0;

  assign hit = attr.en
            && (px >= x0) && (px < x0 + 11'(SPR_W))
            && (py >= y0) && (py < y0 + 11'(SPR_H));

  // Horizontal mirror reads columns right-to-left
  assign lx = attr.hflip ? (LX_W'(SPR_W - 1) - dx[LX_W-1:0]) : dx[LX_W-1:0];
  assign ly = dy[LY_W-1:0];

  assign unused_bits = ^{dx[10:LX_W], dy[10:LY_W], attr.frame};

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - 3-stage sprite/bullet/background compositor; option macro SPRITE_COMPOSITOR_COLLISION_EN
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int     NUM_SPRITES = 8,
  parameter int     SPR_W       = 32,
  parameter int     SPR_H       = 32,
  parameter int     NUM_FRAMES  = 8,
  parameter int     NUM_BULLETS = 16,
  parameter int     BULLET_R    = 4,
  parameter rgb24_t BULLET_RGB  = 24'hFF5500,
  parameter rgb24_t KEY_RGB     = 24'h000000,
  localparam int    IDX_W  = $clog2(NUM_SPRITES),
  localparam int    ADDR_W = $clog2(NUM_SPRITES * SPR_H * NUM_FRAMES * SPR_W),
  localparam int    LX_W   = $clog2(SPR_W),
  localparam int    LY_W   = $clog2(SPR_H)
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          pix_valid,
  input  logic                          frame_start,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic                          attr_we,
  input  logic [IDX_W-1:0]              attr_addr,
  input  logic [31:0]                   attr_wdata,
  input  logic [NUM_BULLETS*32-1:0]     bullet_array,
  output logic [ADDR_W-1:0]             sheet_addr,
  input  logic [23:0]                   sheet_rdata,
  input  logic [23:0]                   bg_rgb,
  output logic [7:0]                    Red,
  output logic [7:0]                    Green,
  output logic [7:0]                    Blue,
  output logic                          rgb_valid,
  input  logic                          coll_clr,
  output logic [NUM_SPRITES-1:0]        coll_flags
);

  localparam logic signed [23:0] R_SQ = 24'(BULLET_R * BULLET_R);

  attr_t active_bank [NUM_SPRITES];
  attr_t shadow_bank [NUM_SPRITES];
  attr_t wr_attr;
  logic  unused_wdata;

  // Decode the incoming attribute word
  always_comb begin
    wr_attr.en    = attr_wdata[ATTR_EN_BIT];
    wr_attr.x     = attr_wdata[ATTR_X_LSB +: COORD_W];
    wr_attr.y     = attr_wdata[ATTR_Y_LSB +: COORD_W];
    wr_attr.frame = attr_wdata[ATTR_FRAME_LSB +: ATTR_FRAME_W];
    wr_attr.hflip = attr_wdata[ATTR_HFLIP_BIT];
  end
  assign unused_wdata = ^attr_wdata[31:25];

  // Software writes the active bank; frame_start copies it to the drawing bank, forwarding a same-cycle write
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        active_bank[i] <= '0;
        shadow_bank[i] <= '0;
      end
    end else begin
      if (attr_we) active_bank[attr_addr] <= wr_attr;
      if (frame_start) begin
        for (int i = 0; i < NUM_SPRITES; i++)
          shadow_bank[i] <= (attr_we && attr_addr == IDX_W'(i)) ? wr_attr : active_bank[i];
      end
    end
  end

  logic       s0_valid;
  logic [9:0] s0_x, s0_y;

  // Stage 0: sample the pixel coordinate
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s0_valid <= 1'b0;
      s0_x     <= '0;
      s0_y     <= '0;
    end else begin
      s0_valid <= pix_valid;
      s0_x     <= DrawX;
      s0_y     <= DrawY;
    end
  end

  logic [NUM_SPRITES-1:0] hit_vec;
  logic [LX_W-1:0]        lx_arr [NUM_SPRITES];
  logic [LY_W-1:0]        ly_arr [NUM_SPRITES];

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit_unit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .attr   (shadow_bank[g]),
      .draw_x (s0_x),
      .draw_y (s0_y),
      .hit    (hit_vec[g]),
      .lx     (lx_arr[g]),
      .ly     (ly_arr[g])
    );
  end

  logic                    sel_hit;
  logic [IDX_W-1:0]        sel_idx;
  logic [LX_W-1:0]         sel_lx;
  logic [LY_W-1:0]         sel_ly;
  logic [ATTR_FRAME_W-1:0] sel_f;
  logic [ADDR_W-1:0]       addr_next;

  // Priority encoder: scanning downward leaves the lowest-index hit selected
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    sel_lx  = '0;
    sel_ly  = '0;
    sel_f   = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_hit = 1'b1;
        sel_idx = IDX_W'(i);
        sel_lx  = lx_arr[i];
        sel_ly  = ly_arr[i];
        sel_f   = shadow_bank[i].frame;
      end
    end
    addr_next = '0;
    if (sel_hit)
      addr_next = ((ADDR_W'(sel_idx) * ADDR_W'(SPR_H) + ADDR_W'(sel_ly)) * ADDR_W'(NUM_FRAMES)
                  + (ADDR_W'(sel_f) & ADDR_W'(NUM_FRAMES - 1))) * ADDR_W'(SPR_W) + ADDR_W'(sel_lx);
  end

  logic                   bul_any;
  logic [NUM_BULLETS-1:0] unused_bul;

  // Any valid bullet whose disc covers the stage-0 pixel
  always_comb begin
    bul_any = 1'b0;
    for (int j = 0; j < NUM_BULLETS; j++) begin
      unused_bul[j] = ^{bullet_array[j*BUL_WORD_W + 1 +: 8], bullet_array[j*BUL_WORD_W + 29 +: 3]};
      if (bullet_array[j*BUL_WORD_W + BUL_VALID_BIT]
          && bullet_in_radius(s0_x, s0_y,
                              bullet_array[j*BUL_WORD_W + BUL_X_LSB +: COORD_W],
                              bullet_array[j*BUL_WORD_W + BUL_Y_LSB +: COORD_W], R_SQ))
        bul_any = 1'b1;
    end
  end

  logic s1_valid, s1_hit, s1_bul;
  logic s2_valid, s2_hit, s2_bul;

  // Stage 1 registers the ROM address; stage 2 aligns flags with ROM data
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sheet_addr <= '0;
      s1_valid   <= 1'b0;
      s1_hit     <= 1'b0;
      s1_bul     <= 1'b0;
      s2_valid   <= 1'b0;
      s2_hit     <= 1'b0;
      s2_bul     <= 1'b0;
    end else begin
      sheet_addr <= addr_next;
      s1_valid   <= s0_valid;
      s1_hit     <= sel_hit;
      s1_bul     <= bul_any;
      s2_valid   <= s1_valid;
      s2_hit     <= s1_hit;
      s2_bul     <= s1_bul;
    end
  end

  rgb24_t out_rgb;

  // Stage 3: an opaque sprite texel beats bullets, which beat the background
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_rgb   <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= s2_valid;
      if (!s2_valid)                              out_rgb <= '0;
      else if (s2_hit && sheet_rdata != KEY_RGB)  out_rgb <= sheet_rdata;
      else if (s2_bul)                            out_rgb <= BULLET_RGB;
      else                                        out_rgb <= bg_rgb;
    end
  end

  assign Red   = out_rgb[23:16];
  assign Green = out_rgb[15:8];
  assign Blue  = out_rgb[7:0];

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
  logic [NUM_SPRITES-1:0] coll_q;

  // Sticky sprite/bullet overlap flags; a set in the clearing cycle wins
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      coll_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (s0_valid && hit_vec[i] && bul_any) coll_q[i] <= 1'b1;
        else if (coll_clr)                     coll_q[i] <= 1'b0;
      end
    end
  end
  assign coll_flags = coll_q;
`else
  logic unused_coll_clr;
  assign unused_coll_clr = coll_clr;
  assign coll_flags      = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed self-checking bench for sprite_compositor
module tb_sprite_compositor;

  localparam logic [23:0] BG   = 24'h203040;
  localparam logic [23:0] BRGB = 24'hFF5500;
`ifdef SPRITE_COMPOSITOR_COLLISION_EN
  localparam logic [7:0]  COLL_EXP = 8'h04;
`else
  localparam logic [7:0]  COLL_EXP = 8'h00;
`endif

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b1;
  logic         pix_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic [9:0]   DrawX = '0;
  logic [9:0]   DrawY = '0;
  logic         attr_we = 1'b0;
  logic [2:0]   attr_addr = '0;
  logic [31:0]  attr_wdata = '0;
  logic [511:0] bullet_array = '0;
  logic [15:0]  sheet_addr;
  logic [23:0]  sheet_rdata = '0;
  logic [23:0]  bg_rgb = BG;
  logic [7:0]   Red, Green, Blue;
  logic         rgb_valid;
  logic         coll_clr = 1'b0;
  logic [7:0]   coll_flags;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        key_en = 1'b0;
  logic [15:0] key_addr = '0;

  logic [15:0] a;
  logic [23:0] c;
  logic        v;

  sprite_compositor dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .pix_valid    (pix_valid),
    .frame_start  (frame_start),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .attr_we      (attr_we),
    .attr_addr    (attr_addr),
    .attr_wdata   (attr_wdata),
    .bullet_array (bullet_array),
    .sheet_addr   (sheet_addr),
    .sheet_rdata  (sheet_rdata),
    .bg_rgb       (bg_rgb),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue),
    .rgb_valid    (rgb_valid),
    .coll_clr     (coll_clr),
    .coll_flags   (coll_flags)
  );

  always #5 CLK = ~CLK;

  function automatic logic [23:0] hash(input logic [15:0] ad);
    return {ad[7:0], ad[15:8] ^ 8'h5A, 8'hC3};
  endfunction

  // Synchronous sprite-sheet ROM model
  always @(posedge CLK)
    sheet_rdata <= (key_en && sheet_addr == key_addr) ? 24'h000000 : hash(sheet_addr);

  function automatic logic [31:0] mk_attr(input logic en, input logic [9:0] x, input logic [9:0] y,
                                          input logic [2:0] f, input logic hf);
    return {7'b0, hf, f, y, x, en};
  endfunction

  function automatic logic [31:0] mk_bullet(input logic [9:0] cx, input logic [9:0] cy);
    return {3'b0, cy, cx, 8'b0, 1'b1};
  endfunction

  task automatic write_attr(input logic [2:0] idx, input logic [31:0] w);
    attr_we = 1'b1; attr_addr = idx; attr_wdata = w;
    @(posedge CLK); #1;
    attr_we = 1'b0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(posedge CLK); #1;
    frame_start = 1'b0;
  endtask

  task automatic run_pixel(input logic [9:0] x, input logic [9:0] y,
                           output logic [15:0] ad, output logic [23:0] rgb, output logic vld);
    DrawX = x; DrawY = y; pix_valid = 1'b1;
    @(posedge CLK); #1;
    pix_valid = 1'b0;
    @(posedge CLK); #1;
    ad = sheet_addr;
    @(posedge CLK);
    @(posedge CLK); #1;
    rgb = {Red, Green, Blue};
    vld = rgb_valid;
  endtask

  task automatic test_reset();
    #2 RESET_N = 1'b0;
    @(posedge CLK); #1;
    total_cnt++; if ({Red, Green, Blue} !== 24'h0) $display("FAIL reset_rgb: got %h want 000000", {Red, Green, Blue}); else pass_cnt++;
    total_cnt++; if (rgb_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rgb_valid); else pass_cnt++;
    total_cnt++; if (sheet_addr !== 16'd0) $display("FAIL reset_addr: got %0d want 0", sheet_addr); else pass_cnt++;
    total_cnt++; if (coll_flags !== 8'h00) $display("FAIL reset_coll: got %h want 00", coll_flags); else pass_cnt++;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    run_pixel(10'd100, 10'd50, a, c, v);
    total_cnt++; if (c !== BG) $display("FAIL reset_disabled_rgb: got %h want %h", c, BG); else pass_cnt++;
  endtask

  task automatic test_single_sprite();
    write_attr(3'd0, mk_attr(1'b1, 10'd100, 10'd50, 3'd2, 1'b0));
    pulse_frame_start();
    run_pixel(10'd100, 10'd50, a, c, v);
    total_cnt++; if (a !== 16'd64) $display("FAIL single_addr: got %0d want 64", a); else pass_cnt++;
    total_cnt++; if (c !== hash(16'd64)) $display("FAIL single_rgb: got %h want %h", c, hash(16'd64)); else pass_cnt++;
    total_cnt++; if (v !== 1'b1) $display("FAIL single_valid: got %b want 1", v); else pass_cnt++;
    run_pixel(10'd105, 10'd53, a, c, v);
    total_cnt++; if (a !== 16'd837) $display("FAIL single_addr2: got %0d want 837", a); else pass_cnt++;
    total_cnt++; if (c !== hash(16'd837)) $display("FAIL single_rgb2: got %h want %h", c, hash(16'd837)); else pass_cnt++;
    run_pixel(10'd131, 10'd81, a, c, v);
    total_cnt++; if (a !== 16'd8031) $display("FAIL single_corner: got %0d want 8031", a); else pass_cnt++;
    run_pixel(10'd132, 10'd50, a, c, v);
    total_cnt++; if (a !== 16'd0) $display("FAIL single_miss_addr: got %0d want 0", a); else pass_cnt++;
    total_cnt++; if (c !== BG) $display("FAIL single_miss_rgb: got %h want %h", c, BG); else pass_cnt++;
  endtask

  task automatic test_priority();
    write_attr(3'd0, mk_attr(1'b1, 10'd195, 10'd195, 3'd1, 1'b0));
    write_attr(3'd3, mk_attr(1'b1, 10'd190, 10'd190, 3'd0, 1'b0));
    pulse_frame_start();
    run_pixel(10'd200, 10'd200, a, c, v);
    total_cnt++; if (a !== 16'd1317) $display("FAIL prio_addr: got %0d want 1317", a); else pass_cnt++;
    total_cnt++; if (c !== hash(16'd1317)) $display("FAIL prio_rgb: got %h want %h", c, hash(16'd1317)); else pass_cnt++;
    key_en = 1'b1; key_addr = 16'd1317;
    run_pixel(10'd200, 10'd200, a, c, v);
    total_cnt++; if (c !== BG) $display("FAIL prio_key_bg: got %h want %h", c, BG); else pass_cnt++;
    bullet_array[5*32 +: 32] = mk_bullet(10'd200, 10'd200);
    run_pixel(10'd200, 10'd200, a, c, v);
    total_cnt++; if (c !== BRGB) $display("FAIL prio_key_bullet: got %h want %h", c, BRGB); else pass_cnt++;
    key_en = 1'b0;
    run_pixel(10'd200, 10'd200, a, c, v);
    total_cnt++; if (c !== hash(16'd1317)) $display("FAIL prio_sprite_over_bullet: got %h want %h", c, hash(16'd1317)); else pass_cnt++;
  endtask

  task automatic test_bullet_radius();
    bullet_array[7*32 +: 32] = mk_bullet(10'd500, 10'd400);
    run_pixel(10'd504, 10'd400, a, c, v);
    total_cnt++; if (c !== BRGB) $display("FAIL bul_r_edge: got %h want %h", c, BRGB); else pass_cnt++;
    run_pixel(10'd505, 10'd400, a, c, v);
    total_cnt++; if (c !== BG) $display("FAIL bul_r_out: got %h want %h", c, BG); else pass_cnt++;
    run_pixel(10'd496, 10'd400, a, c, v);
    total_cnt++; if (c !== BRGB) $display("FAIL bul_neg_dx: got %h want %h", c, BRGB); else pass_cnt++;
    run_pixel(10'd503, 10'd403, a, c, v);
    total_cnt++; if (c !== BG) $display("FAIL bul_diag_out: got %h want %h", c, BG); else pass_cnt++;
    run_pixel(10'd502, 10'd402, a, c, v);
    total_cnt++; if (c !== BRGB) $display("FAIL bul_diag_in: got %h want %h", c, BRGB); else pass_cnt++;
  endtask

  task automatic test_double_buffer();
    write_attr(3'd1, mk_attr(1'b1, 10'd300, 10'd10, 3'd0, 1'b0));
    pulse_frame_start();
    run_pixel(10'd300, 10'd10, a, c, v);
    total_cnt++; if (a !== 16'd8192) $display("FAIL dbuf_initial: got %0d want 8192", a); else pass_cnt++;
    write_attr(3'd1, mk_attr(1'b1, 10'd400, 10'd10, 3'd0, 1'b0));
    run_pixel(10'd300, 10'd10, a, c, v);
    total_cnt++; if (a !== 16'd8192) $display("FAIL dbuf_old_kept: got %0d want 8192", a); else pass_cnt++;
    run_pixel(10'd400, 10'd10, a, c, v);
    total_cnt++; if (a !== 16'd0) $display("FAIL dbuf_new_hidden: got %0d want 0", a); else pass_cnt++;
    pulse_frame_start();
    run_pixel(10'd400, 10'd10, a, c, v);
    total_cnt++; if (a !== 16'd8192) $display("FAIL dbuf_swapped: got %0d want 8192", a); else pass_cnt++;
    run_pixel(10'd300, 10'd10, a, c, v);
    total_cnt++; if (a !== 16'd0) $display("FAIL dbuf_old_gone: got %0d want 0", a); else pass_cnt++;
    attr_we = 1'b1; attr_addr = 3'd1; attr_wdata = mk_attr(1'b1, 10'd600, 10'd10, 3'd0, 1'b0);
    frame_start = 1'b1;
    @(posedge CLK); #1;
    attr_we = 1'b0; frame_start = 1'b0;
    run_pixel(10'd600, 10'd10, a, c, v);
    total_cnt++; if (a !== 16'd8192) $display("FAIL dbuf_forward: got %0d want 8192", a); else pass_cnt++;
  endtask

  task automatic test_edges();
    write_attr(3'd2, mk_attr(1'b1, 10'd1000, 10'd100, 3'd0, 1'b0));
    write_attr(3'd4, mk_attr(1'b1, 10'd10, 10'd300, 3'd0, 1'b1));
    pulse_frame_start();
    run_pixel(10'd1000, 10'd100, a, c, v);
    total_cnt++; if (a !== 16'd16384) $display("FAIL edge_left: got %0d want 16384", a); else pass_cnt++;
    run_pixel(10'd1023, 10'd100, a, c, v);
    total_cnt++; if (a !== 16'd16407) $display("FAIL edge_1023: got %0d want 16407", a); else pass_cnt++;
    run_pixel(10'd0, 10'd101, a, c, v);
    total_cnt++; if (a !== 16'd0) $display("FAIL edge_nowrap0: got %0d want 0", a); else pass_cnt++;
    run_pixel(10'd7, 10'd101, a, c, v);
    total_cnt++; if (a !== 16'd0) $display("FAIL edge_nowrap7: got %0d want 0", a); else pass_cnt++;
    total_cnt++; if (c !== BG) $display("FAIL edge_nowrap_rgb: got %h want %h", c, BG); else pass_cnt++;
    run_pixel(10'd10, 10'd300, a, c, v);
    total_cnt++; if (a !== 16'd32799) $display("FAIL hflip_col0: got %0d want 32799", a); else pass_cnt++;
    run_pixel(10'd41, 10'd300, a, c, v);
    total_cnt++; if (a !== 16'd32768) $display("FAIL hflip_col31: got %0d want 32768", a); else pass_cnt++;
  endtask

  task automatic test_collision();
    coll_clr = 1'b1;
    @(posedge CLK); #1;
    coll_clr = 1'b0;
    total_cnt++; if (coll_flags !== 8'h00) $display("FAIL coll_cleared: got %h want 00", coll_flags); else pass_cnt++;
    bullet_array[9*32 +: 32] = mk_bullet(10'd1010, 10'd100);
    run_pixel(10'd1010, 10'd100, a, c, v);
    total_cnt++; if (coll_flags !== COLL_EXP) $display("FAIL coll_set: got %h want %h", coll_flags, COLL_EXP); else pass_cnt++;
    total_cnt++; if (c !== hash(16'd16394)) $display("FAIL coll_rgb: got %h want %h", c, hash(16'd16394)); else pass_cnt++;
    coll_clr = 1'b1;
    @(posedge CLK); #1;
    coll_clr = 1'b0;
    total_cnt++; if (coll_flags !== 8'h00) $display("FAIL coll_clr: got %h want 00", coll_flags); else pass_cnt++;
    DrawX = 10'd1010; DrawY = 10'd100; pix_valid = 1'b1;
    @(posedge CLK); #1;
    pix_valid = 1'b0; coll_clr = 1'b1;
    @(posedge CLK); #1;
    coll_clr = 1'b0;
    total_cnt++; if (coll_flags !== COLL_EXP) $display("FAIL coll_set_wins: got %h want %h", coll_flags, COLL_EXP); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    DrawX = 10'd1010; DrawY = 10'd100; pix_valid = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b0;
    #2;
    total_cnt++; if ({Red, Green, Blue} !== 24'h0) $display("FAIL mid_reset_rgb: got %h want 000000", {Red, Green, Blue}); else pass_cnt++;
    total_cnt++; if (rgb_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", rgb_valid); else pass_cnt++;
    total_cnt++; if (coll_flags !== 8'h00) $display("FAIL mid_reset_coll: got %h want 00", coll_flags); else pass_cnt++;
    pix_valid = 1'b0;
    bullet_array = '0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    pulse_frame_start();
    DrawX = 10'd1010; DrawY = 10'd100; pix_valid = 1'b1;
    @(posedge CLK); #1;
    pix_valid = 1'b0;
    @(posedge CLK); #1;
    total_cnt++; if (sheet_addr !== 16'd0) $display("FAIL mid_addr_disabled: got %0d want 0", sheet_addr); else pass_cnt++;
    @(posedge CLK); #1;
    total_cnt++; if (rgb_valid !== 1'b0) $display("FAIL mid_early_valid: got %b want 0", rgb_valid); else pass_cnt++;
    @(posedge CLK); #1;
    total_cnt++; if ({Red, Green, Blue} !== BG) $display("FAIL mid_bg_rgb: got %h want %h", {Red, Green, Blue}, BG); else pass_cnt++;
    total_cnt++; if (rgb_valid !== 1'b1) $display("FAIL mid_bg_valid: got %b want 1", rgb_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_sprite();
    test_priority();
    test_bullet_radius();
    test_double_buffer();
    test_edges();
    test_collision();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
